// File: rtl/ws2812_tx.sv
// WS2812 one-wire serializer: GRB pixels in over valid/ready, NRZ bit waveforms plus latch interval out.
// Define WS2812_UNDERRUN_EN to add the underrun pulse port (frame aborted by upstream stall timeout).
module ws2812_tx #(
   parameter int unsigned NUM_LEDS  = 60,
   parameter int unsigned BIT_CYC   = 63,
   parameter int unsigned T0H_CYC   = 20,
   parameter int unsigned T1H_CYC   = 40,
   parameter int unsigned RESET_CYC = 3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] pixel_data,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   output logic        ws2812_dout,
   output logic        busy,
   output logic        frame_done
`ifdef WS2812_UNDERRUN_EN
  ,output logic        underrun
`endif
);

   localparam int unsigned PIX_W   = 24;
   localparam int unsigned CYC_MAX = (RESET_CYC > BIT_CYC) ? RESET_CYC : BIT_CYC;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX) + 1;
   localparam int unsigned BIT_W   = $clog2(PIX_W - 1) + 1;
   localparam int unsigned LED_W   = $clog2(NUM_LEDS) + 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_LATCH} state_t;

   state_t             state, state_nx;
   logic [PIX_W-1:0]   shreg, shreg_nx;
   logic [BIT_W-1:0]   bit_cnt, bit_nx;
   logic [CYC_W-1:0]   cyc_cnt, cyc_nx;
   logic [LED_W-1:0]   led_cnt, led_nx;
   logic [CYC_W-1:0]   th_cyc;
   logic               xfer, bit_end, timeout, last_led;
   logic               ready_nx, dout_nx, busy_nx, done_nx;
`ifdef WS2812_UNDERRUN_EN
   logic               underrun_nx;
`endif

   // Next-state, counters and next values of the registered outputs
   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      bit_nx   = bit_cnt;
      cyc_nx   = cyc_cnt;
      led_nx   = led_cnt;
      dout_nx  = 1'b0;
      done_nx  = 1'b0;
`ifdef WS2812_UNDERRUN_EN
      underrun_nx = 1'b0;
`endif
      xfer     = pixel_valid & pixel_ready;
      bit_end  = (cyc_cnt == CYC_W'(BIT_CYC - 1));
      timeout  = (cyc_cnt == CYC_W'(RESET_CYC));
      last_led = (led_cnt == LED_W'(NUM_LEDS - 1));
      th_cyc   = shreg[PIX_W-1] ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);

      case (state)
         S_IDLE: begin
            if (xfer) begin
               shreg_nx = pixel_data;
               bit_nx   = BIT_W'(PIX_W - 1);
               cyc_nx   = '0;
               led_nx   = '0;
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            dout_nx = (cyc_cnt < th_cyc);
            if (!bit_end) begin
               cyc_nx = cyc_cnt + CYC_W'(1);
            end else begin
               cyc_nx = '0;
               if (bit_cnt != '0) begin
                  shreg_nx = {shreg[PIX_W-2:0], 1'b0};
                  bit_nx   = bit_cnt - BIT_W'(1);
               end else begin
                  led_nx = led_cnt + LED_W'(1);
                  if (last_led) begin
                     state_nx = S_LATCH;
                  end else if (xfer) begin
                     shreg_nx = pixel_data;
                     bit_nx   = BIT_W'(PIX_W - 1);
                  end else begin
                     state_nx = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            // A transfer arriving on the timeout cycle still continues the frame
            if (xfer) begin
               shreg_nx = pixel_data;
               bit_nx   = BIT_W'(PIX_W - 1);
               cyc_nx   = '0;
               state_nx = S_SEND;
            end else if (timeout) begin
               cyc_nx   = '0;
               led_nx   = '0;
               state_nx = S_IDLE;
`ifdef WS2812_UNDERRUN_EN
               underrun_nx = 1'b1;
`endif
            end else begin
               cyc_nx = cyc_cnt + CYC_W'(1);
            end
         end
         S_LATCH: begin
            if (timeout) begin
               cyc_nx   = '0;
               led_nx   = '0;
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               cyc_nx = cyc_cnt + CYC_W'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Ready is registered, so it is derived from where the counters will be next cycle
      ready_nx = (state_nx == S_IDLE) || (state_nx == S_WAIT) ||
                 ((state_nx == S_SEND) && (cyc_nx == CYC_W'(BIT_CYC - 1)) &&
                  (bit_nx == '0) && (led_nx != LED_W'(NUM_LEDS - 1)));
      busy_nx  = (state_nx != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         cyc_cnt     <= '0;
         led_cnt     <= '0;
         pixel_ready <= 1'b0;
         ws2812_dout <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
`ifdef WS2812_UNDERRUN_EN
         underrun    <= 1'b0;
`endif
      end else begin
         state       <= state_nx;
         shreg       <= shreg_nx;
         bit_cnt     <= bit_nx;
         cyc_cnt     <= cyc_nx;
         led_cnt     <= led_nx;
         pixel_ready <= ready_nx;
         ws2812_dout <= dout_nx;
         busy        <= busy_nx;
         frame_done  <= done_nx;
`ifdef WS2812_UNDERRUN_EN
         underrun    <= underrun_nx;
`endif
      end
   end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: three instances (1, 3 and 4 LEDs per frame) sharing clk/rst_n.
// Waveforms are recorded one sample per cycle, #1 after each rising edge, and checked afterwards.
module tb_ws2812_tx;

   localparam int BIT_CYC = 63;
   localparam int T0H     = 20;
   localparam int T1H     = 40;
   localparam int RST_CYC = 3000;
   localparam int PIX_CYC = 24 * BIT_CYC;
   localparam int LAT     = PIX_CYC + 1 + RST_CYC;  // last-pixel transfer index -> frame_done index
   localparam int WMAX    = 12000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld  [3];
   logic [23:0] dat  [3];
   logic        rdy  [3];
   logic        dout [3];
   logic        bsy  [3];
   logic        fd   [3];
`ifdef WS2812_UNDERRUN_EN
   logic        ur   [3];
`endif

   int          vectors = 0;
   int          errors  = 0;
   logic [1:0]  sel = 2'd0;
   logic [23:0] pix_q[$];
   logic        wave  [WMAX];
   logic        rwave [WMAX];
   logic        bwave [WMAX];
   int          wlen;
   int          xfer_at[$];
   int          fd_at[$];
   int          ur_at[$];

   always #5 clk = ~clk;

   ws2812_tx #(.NUM_LEDS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .pixel_data(dat[0]), .pixel_valid(vld[0]),
      .pixel_ready(rdy[0]), .ws2812_dout(dout[0]), .busy(bsy[0]), .frame_done(fd[0])
`ifdef WS2812_UNDERRUN_EN
      , .underrun(ur[0])
`endif
   );
   ws2812_tx #(.NUM_LEDS(3)) u3 (
      .clk(clk), .rst_n(rst_n), .pixel_data(dat[1]), .pixel_valid(vld[1]),
      .pixel_ready(rdy[1]), .ws2812_dout(dout[1]), .busy(bsy[1]), .frame_done(fd[1])
`ifdef WS2812_UNDERRUN_EN
      , .underrun(ur[1])
`endif
   );
   ws2812_tx #(.NUM_LEDS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .pixel_data(dat[2]), .pixel_valid(vld[2]),
      .pixel_ready(rdy[2]), .ws2812_dout(dout[2]), .busy(bsy[2]), .frame_done(fd[2])
`ifdef WS2812_UNDERRUN_EN
      , .underrun(ur[2])
`endif
   );

   task automatic begin_rec();
      wlen = 0;
      xfer_at.delete();
      fd_at.delete();
      ur_at.delete();
   endtask

   task automatic drive();
      vld[sel] = (pix_q.size() != 0);
      dat[sel] = (pix_q.size() != 0) ? pix_q[0] : 24'h0;
   endtask

   // Feed queued pixels to the selected instance and record its outputs for ncyc cycles
   task automatic capture(input int ncyc);
      logic fire;
      for (int i = 0; i < ncyc; i++) begin
         drive();
         fire = vld[sel] & rdy[sel];
         @(posedge clk);
         #1;
         if (fire) begin
            void'(pix_q.pop_front());
            xfer_at.push_back(wlen);
         end
         drive();
         if (wlen < WMAX) begin
            wave[wlen]  = dout[sel];
            rwave[wlen] = rdy[sel];
            bwave[wlen] = bsy[sel];
         end
         if (fd[sel]) fd_at.push_back(wlen);
`ifdef WS2812_UNDERRUN_EN
         if (ur[sel]) ur_at.push_back(wlen);
`endif
         wlen++;
      end
   endtask

   function automatic int xt(input int j);
      return (j < xfer_at.size()) ? xfer_at[j] : 0;
   endfunction

   function automatic int fdt(input int j);
      return (j < fd_at.size()) ? fd_at[j] : -1;
   endfunction

   // Number of 1 samples in [a,b] of wave (0), rwave (1) or bwave (2)
   function automatic int ones(input int a, input int b, input int which);
      int n;
      n = 0;
      for (int i = a; i <= b; i++) begin
         if (i >= 0 && i < WMAX) begin
            if (which == 0 && wave[i])  n++;
            if (which == 1 && rwave[i]) n++;
            if (which == 2 && bwave[i]) n++;
         end
      end
      return n;
   endfunction

   // First bit (0 = G7) whose 63-cycle period is not a single high pulse of the right length, else -1
   function automatic int pix_bad(input int t, input logic [23:0] p, output int got_hi, output int want_hi);
      for (int b = 0; b < 24; b++) begin
         int   hi;
         int   lead;
         logic run;
         logic s;
         hi = 0;
         lead = 0;
         run = 1'b1;
         want_hi = p[23-b] ? T1H : T0H;
         for (int c = 0; c < BIT_CYC; c++) begin
            int idx;
            idx = t + 1 + b * BIT_CYC + c;
            s = (idx < WMAX) ? wave[idx] : 1'b0;
            if (s) hi++;
            if (run && s) lead++;
            else run = 1'b0;
         end
         got_hi = hi;
         if (hi != want_hi || lead != want_hi) return b;
      end
      got_hi = 0;
      want_hi = 0;
      return -1;
   endfunction

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         vld[d] = 1'b0;
         dat[d] = 24'h0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if (rdy[d] !== 1'b0 || dout[d] !== 1'b0 || bsy[d] !== 1'b0 || fd[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: ready=%b dout=%b busy=%b done=%b, want all 0",
                     d, rdy[d], dout[d], bsy[d], fd[d]);
         end
`ifdef WS2812_UNDERRUN_EN
         vectors++;
         if (ur[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_underrun dut%0d: got %b want 0", d, ur[d]);
         end
`endif
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b want 0", rdy[0]);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if (rdy[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release dut%0d: got %b want 1", d, rdy[d]);
         end
      end
   endtask

   task automatic test_single_pixel();
      int t, gh, wh, bb;
      sel = 2'd0;
      begin_rec();
      pix_q.push_back(24'h800000);
      capture(LAT + 3);
      t = xt(0);
      vectors++;
      if (xfer_at.size() != 1 || t != 0) begin
         errors++;
         $display("FAIL t1_transfer: count %0d first %0d, want 1 at 0", xfer_at.size(), t);
      end
      vectors++;
      if (wave[t] !== 1'b0 || wave[t+1] !== 1'b1) begin
         errors++;
         $display("FAIL t1_latency: dout %b,%b after transfer edge, want 0,1", wave[t], wave[t+1]);
      end
      bb = pix_bad(t, 24'h800000, gh, wh);
      vectors++;
      if (bb != -1) begin
         errors++;
         $display("FAIL t1_pixel bit %0d: high %0d cycles, want %0d", bb, gh, wh);
      end
      vectors++;
      if (ones(t + PIX_CYC + 1, t + LAT - 1, 0) != 0 || ones(t + PIX_CYC + 1, t + LAT - 1, 2) != RST_CYC) begin
         errors++;
         $display("FAIL t1_latch: dout high %0d busy %0d over latch, want 0 and %0d",
                  ones(t + PIX_CYC + 1, t + LAT - 1, 0), ones(t + PIX_CYC + 1, t + LAT - 1, 2), RST_CYC);
      end
      vectors++;
      if (fd_at.size() != 1 || fdt(0) != t + LAT) begin
         errors++;
         $display("FAIL t1_frame_done: %0d pulses first at %0d, want 1 at %0d", fd_at.size(), fdt(0), t + LAT);
      end
      vectors++;
      if (bwave[t+LAT] !== 1'b0 || bwave[t+LAT-1] !== 1'b1) begin
         errors++;
         $display("FAIL t1_busy_fall: busy %b,%b, want 1,0", bwave[t+LAT-1], bwave[t+LAT]);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] px [3];
      int gh, wh, bb;
      px[0] = 24'hA50FC3;
      px[1] = 24'h5A3C96;
      px[2] = 24'hFF00FF;
      sel = 2'd1;
      begin_rec();
      for (int j = 0; j < 3; j++) pix_q.push_back(px[j]);
      capture(3 * PIX_CYC + LAT + 3);
      vectors++;
      if (xfer_at.size() != 3 || xt(1) - xt(0) != PIX_CYC || xt(2) - xt(1) != PIX_CYC) begin
         errors++;
         $display("FAIL t2_contiguous: %0d transfers at %0d,%0d,%0d, want 3 spaced %0d",
                  xfer_at.size(), xt(0), xt(1), xt(2), PIX_CYC);
      end
      for (int j = 0; j < 3; j++) begin
         bb = pix_bad(xt(j), px[j], gh, wh);
         vectors++;
         if (bb != -1) begin
            errors++;
            $display("FAIL t2_pix%0d bit %0d: high %0d cycles, want %0d", j, bb, gh, wh);
         end
      end
      vectors++;
      if (fd_at.size() != 1 || fdt(0) != xt(2) + LAT) begin
         errors++;
         $display("FAIL t2_frame_done: %0d pulses first at %0d, want 1 at %0d", fd_at.size(), fdt(0), xt(2) + LAT);
      end
   endtask

   task automatic test_stall();
      logic [23:0] px [4];
      int gh, wh, bb;
      px[0] = 24'h123456;
      px[1] = 24'hFEDCBA;
      px[2] = 24'h0F0F0F;
      px[3] = 24'hC0FFEE;
      sel = 2'd2;
      begin_rec();
      pix_q.push_back(px[0]);
      pix_q.push_back(px[1]);
      capture(PIX_CYC + 1);
      capture(PIX_CYC + 99);
      pix_q.push_back(px[2]);
      pix_q.push_back(px[3]);
      capture(2 * PIX_CYC + LAT + 3);
      vectors++;
      if (xfer_at.size() != 4 || xt(1) - xt(0) != PIX_CYC || xt(2) - xt(1) != PIX_CYC + 100 ||
          xt(3) - xt(2) != PIX_CYC) begin
         errors++;
         $display("FAIL t3_transfers: %0d at %0d,%0d,%0d,%0d, want 4 at 0,%0d,%0d,%0d",
                  xfer_at.size(), xt(0), xt(1), xt(2), xt(3), PIX_CYC, 2 * PIX_CYC + 100, 3 * PIX_CYC + 100);
      end
      vectors++;
      if (ones(xt(1) + PIX_CYC + 1, xt(2), 0) != 0) begin
         errors++;
         $display("FAIL t3_stall_low: dout high %0d cycles during stall, want 0", ones(xt(1) + PIX_CYC + 1, xt(2), 0));
      end
      for (int j = 0; j < 4; j++) begin
         bb = pix_bad(xt(j), px[j], gh, wh);
         vectors++;
         if (bb != -1) begin
            errors++;
            $display("FAIL t3_pix%0d bit %0d: high %0d cycles, want %0d", j, bb, gh, wh);
         end
      end
      vectors++;
      if (fd_at.size() != 1 || fdt(0) != xt(3) + LAT) begin
         errors++;
         $display("FAIL t3_frame_done: %0d pulses first at %0d, want 1 at %0d", fd_at.size(), fdt(0), xt(3) + LAT);
      end
`ifdef WS2812_UNDERRUN_EN
      vectors++;
      if (ur_at.size() != 0) begin
         errors++;
         $display("FAIL t3_no_underrun: %0d pulses, want 0", ur_at.size());
      end
`endif
   endtask

   task automatic test_underrun();
      int t1;
      sel = 2'd2;
      begin_rec();
      pix_q.push_back(24'hAAAAAA);
      pix_q.push_back(24'h555555);
      capture(PIX_CYC + 1);
      capture(PIX_CYC + RST_CYC + 3);
      t1 = xt(1);
      vectors++;
      if (xfer_at.size() != 2 || t1 != PIX_CYC) begin
         errors++;
         $display("FAIL t4_transfers: %0d, second at %0d, want 2 at %0d", xfer_at.size(), t1, PIX_CYC);
      end
      vectors++;
      if (bwave[t1+LAT] !== 1'b0 || bwave[t1+LAT-1] !== 1'b1 || rwave[t1+LAT] !== 1'b1) begin
         errors++;
         $display("FAIL t4_timeout_idle: busy %b,%b ready %b, want 1,0 and 1",
                  bwave[t1+LAT-1], bwave[t1+LAT], rwave[t1+LAT]);
      end
      vectors++;
      if (fd_at.size() != 0 || ones(t1 + PIX_CYC + 1, t1 + LAT, 0) != 0) begin
         errors++;
         $display("FAIL t4_no_latch_done: done pulses %0d dout high %0d, want 0 and 0",
                  fd_at.size(), ones(t1 + PIX_CYC + 1, t1 + LAT, 0));
      end
`ifdef WS2812_UNDERRUN_EN
      vectors++;
      if (ur_at.size() != 1 || ur_at[0] != t1 + LAT) begin
         errors++;
         $display("FAIL t4_underrun: %0d pulses, want 1 at %0d", ur_at.size(), t1 + LAT);
      end
`endif
      // A full new frame must now take four pixels
      begin_rec();
      for (int j = 0; j < 4; j++) pix_q.push_back(24'h010203 * (j + 1));
      capture(3 * PIX_CYC + LAT + 3);
      vectors++;
      if (xfer_at.size() != 4 || fd_at.size() != 1 || fdt(0) != xt(3) + LAT) begin
         errors++;
         $display("FAIL t4_restart_led0: %0d transfers %0d done pulses first at %0d, want 4, 1 at %0d",
                  xfer_at.size(), fd_at.size(), fdt(0), xt(3) + LAT);
      end
   endtask

   task automatic test_reset_mid_bit();
      sel = 2'd2;
      begin_rec();
      for (int j = 0; j < 3; j++) pix_q.push_back(24'hFFFFFF);
      capture(2 * PIX_CYC + 6);
      vectors++;
      if (wave[2*PIX_CYC+5] !== 1'b1 || bsy[2] !== 1'b1) begin
         errors++;
         $display("FAIL t5_pre_reset: dout %b busy %b, want 1 1", wave[2*PIX_CYC+5], bsy[2]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (dout[2] !== 1'b0 || bsy[2] !== 1'b0 || rdy[2] !== 1'b0) begin
         errors++;
         $display("FAIL t5_async_reset: dout %b busy %b ready %b, want 0 0 0", dout[2], bsy[2], rdy[2]);
      end
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (rdy[2] !== 1'b1) begin
         errors++;
         $display("FAIL t5_ready_release: got %b want 1", rdy[2]);
      end
      begin_rec();
      for (int j = 0; j < 4; j++) pix_q.push_back(24'h00FF00 >> j);
      capture(3 * PIX_CYC + LAT + 3);
      vectors++;
      if (xfer_at.size() != 4 || fd_at.size() != 1 || fdt(0) != xt(3) + LAT) begin
         errors++;
         $display("FAIL t5_new_frame: %0d transfers %0d done pulses first at %0d, want 4, 1 at %0d",
                  xfer_at.size(), fd_at.size(), fdt(0), xt(3) + LAT);
      end
   endtask

   task automatic test_valid_in_latch();
      int t2, f;
      sel = 2'd1;
      begin_rec();
      for (int j = 0; j < 4; j++) pix_q.push_back(24'h808080 + 24'(j));
      capture(3 * PIX_CYC + LAT + 4);
      t2 = xt(2);
      f  = fdt(0);
      vectors++;
      if (fd_at.size() != 1 || f != t2 + LAT) begin
         errors++;
         $display("FAIL t6_frame_done: %0d pulses first at %0d, want 1 at %0d", fd_at.size(), f, t2 + LAT);
      end
      vectors++;
      if (ones(t2 + 1, t2 + LAT - 1, 1) != 0) begin
         errors++;
         $display("FAIL t6_ready_latch: ready high %0d cycles before frame_done, want 0", ones(t2 + 1, t2 + LAT - 1, 1));
      end
      vectors++;
      if (xfer_at.size() != 4 || xt(3) != t2 + LAT + 1) begin
         errors++;
         $display("FAIL t6_held_pixel: %0d transfers, 4th at %0d, want 4 at %0d", xfer_at.size(), xt(3), t2 + LAT + 1);
      end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_stall();
      test_underrun();
      test_reset_mid_bit();
      test_valid_in_latch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
